// File: rtl/matmul_apb_pkg.sv
// Shared constants, state encoding and step-to-register mapping for the
// matmul accelerator APB initiator.
package matmul_apb_pkg;

    localparam int REG_START_ADDR = 1;
    localparam int REG_DONE_ADDR  = 2;
    localparam int REG_FP         = 3;
    localparam int REG_ADDR_A     = 4;
    localparam int REG_ADDR_B     = 5;
    localparam int REG_ADDR_C     = 6;
    localparam int REG_STRIDE_A   = 7;
    localparam int REG_STRIDE_B   = 8;
    localparam int REG_STRIDE_C   = 9;

    localparam int STAT_START = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_EXC   = 2;
    localparam int STAT_FP    = 3;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, POLL_WAIT, DONE} state_t;

    // Register targeted by each step of the launch sequence.
    function automatic logic [31:0] step_addr(input logic [3:0] step);
        case (step)
            4'd0:    return 32'(REG_ADDR_A);
            4'd1:    return 32'(REG_ADDR_B);
            4'd2:    return 32'(REG_ADDR_C);
            4'd3:    return 32'(REG_STRIDE_A);
            4'd4:    return 32'(REG_STRIDE_B);
            4'd5:    return 32'(REG_STRIDE_C);
            4'd6:    return 32'(REG_FP);
            4'd8:    return 32'(REG_DONE_ADDR);
            default: return 32'(REG_START_ADDR);
        endcase
    endfunction

endpackage

// File: rtl/matmul_apb_master_if.sv
// APB bus between the launch initiator (master) and the accelerator's
// register slave.
interface matmul_apb_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
                    input  PRDATA, PREADY);
    modport slave  (input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
                    output PRDATA, PREADY);
endinterface

// File: rtl/apb_poll_timer.sv
// Loadable down-counter that saturates at zero; times the gap between
// status polls and, optionally, the overall poll timeout.
module apb_poll_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   count <= '0;
        else if (load)                count <= load_val;
        else if (en && count != '0)   count <= count - 1'b1;
    end

    assign zero = (count == '0);
endmodule

// File: rtl/matmul_apb_master.sv
// Launch-driven APB initiator for the matmul accelerator register slave.
// Optional poll timeout and timeout_err port: MATMUL_APB_POLL_TIMEOUT_EN.
module matmul_apb_master
    import matmul_apb_pkg::*;
#(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 5,
    parameter int AWIDTH            = 10,
    parameter int ADDR_STRIDE_WIDTH = 8,
    parameter int POLL_GAP          = 4,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         cfg_fp,
    input  logic [AWIDTH-1:0]            cfg_addr_a,
    input  logic [AWIDTH-1:0]            cfg_addr_b,
    input  logic [AWIDTH-1:0]            cfg_addr_c,
    input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_a,
    input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_b,
    input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_c,
    output logic                         busy,
    output logic                         op_done,
    output logic                         op_exception,
`ifdef MATMUL_APB_POLL_TIMEOUT_EN
    output logic                         timeout_err,
`endif
    matmul_apb_master_if.master          apb
);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_t                       state;
    logic [3:0]                   step;
    logic [AWIDTH-1:0]            addr_a_q, addr_b_q, addr_c_q;
    logic [ADDR_STRIDE_WIDTH-1:0] stride_a_q, stride_b_q, stride_c_q;
    logic                         fp_q;

    logic stat_done, stat_exc, poll_exit, poll_abort;
    logic gap_load, gap_en, gap_zero;
    logic unused_prdata;

    assign stat_done     = apb.PRDATA[STAT_DONE];
    assign stat_exc      = apb.PRDATA[STAT_EXC];
    assign unused_prdata = ^{apb.PRDATA[STAT_START], apb.PRDATA[DATA_WIDTH-1:STAT_EXC+1]};
    assign poll_exit     = stat_done | stat_exc | poll_abort;
    assign gap_load      = (state == ACCESS) && apb.PREADY && (step == 4'd8) && !poll_exit;
    assign gap_en        = (state == POLL_WAIT);

    // Gap of N idle cycles: load N-1 and leave POLL_WAIT on the zero count.
    apb_poll_timer #(.WIDTH(GAP_W)) u_gap_timer (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (gap_load),
        .load_val (GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0)),
        .en       (gap_en),
        .zero     (gap_zero)
    );

`ifdef MATMUL_APB_POLL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic to_zero, to_flag;

    apb_poll_timer #(.WIDTH(TO_W)) u_timeout_timer (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     ((state == ACCESS) && apb.PREADY && (step == 4'd7)),
        .load_val (TO_W'(TIMEOUT_CYCLES)),
        .en       (step == 4'd8),
        .zero     (to_zero)
    );
    assign poll_abort = to_zero && (step == 4'd8);
`else
    assign poll_abort = 1'b0;
`endif

    // Write payload for a step, low DATA_WIDTH bits of the zero-extended value.
    function automatic logic [DATA_WIDTH-1:0] step_wdata(
        input logic [3:0] s,
        input logic [AWIDTH-1:0] a, b, c,
        input logic [ADDR_STRIDE_WIDTH-1:0] sa, sb, sc,
        input logic fp);
        logic [63:0] v;
        v = '0;
        case (s)
            4'd0:    v[AWIDTH-1:0] = a;
            4'd1:    v[AWIDTH-1:0] = b;
            4'd2:    v[AWIDTH-1:0] = c;
            4'd3:    v[ADDR_STRIDE_WIDTH-1:0] = sa;
            4'd4:    v[ADDR_STRIDE_WIDTH-1:0] = sb;
            4'd5:    v[ADDR_STRIDE_WIDTH-1:0] = sc;
            4'd6:    v[0] = fp;
            4'd7:    v[0] = 1'b1;
            default: v = '0;
        endcase
        return v[DATA_WIDTH-1:0];
    endfunction

    task automatic issue(input logic [3:0] ns);
        step        <= ns;
        state       <= SETUP;
        apb.PSEL    <= 1'b1;
        apb.PENABLE <= 1'b0;
        apb.PWRITE  <= (ns != 4'd8);
        apb.PADDR   <= ADDR_WIDTH'(step_addr(ns));
        apb.PWDATA  <= step_wdata(ns, addr_a_q, addr_b_q, addr_c_q,
                                  stride_a_q, stride_b_q, stride_c_q, fp_q);
    endtask

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state        <= IDLE;
            step         <= '0;
            cfg_ready    <= 1'b1;
            busy         <= 1'b0;
            op_done      <= 1'b0;
            op_exception <= 1'b0;
            apb.PSEL     <= 1'b0;
            apb.PENABLE  <= 1'b0;
            apb.PWRITE   <= 1'b0;
            apb.PADDR    <= '0;
            apb.PWDATA   <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            addr_c_q     <= '0;
            stride_a_q   <= '0;
            stride_b_q   <= '0;
            stride_c_q   <= '0;
            fp_q         <= 1'b0;
`ifdef MATMUL_APB_POLL_TIMEOUT_EN
            to_flag      <= 1'b0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            op_done <= 1'b0;
            unique case (state)
                IDLE: if (cfg_valid && cfg_ready) begin
                    addr_a_q     <= cfg_addr_a;
                    addr_b_q     <= cfg_addr_b;
                    addr_c_q     <= cfg_addr_c;
                    stride_a_q   <= cfg_stride_a;
                    stride_b_q   <= cfg_stride_b;
                    stride_c_q   <= cfg_stride_c;
                    fp_q         <= cfg_fp;
                    busy         <= 1'b1;
                    cfg_ready    <= 1'b0;
                    op_exception <= 1'b0;
                    step         <= 4'd0;
                    state        <= SETUP;
                    apb.PSEL     <= 1'b1;
                    apb.PENABLE  <= 1'b0;
                    apb.PWRITE   <= 1'b1;
                    apb.PADDR    <= ADDR_WIDTH'(step_addr(4'd0));
                    apb.PWDATA   <= step_wdata(4'd0, cfg_addr_a, cfg_addr_b, cfg_addr_c,
                                               cfg_stride_a, cfg_stride_b, cfg_stride_c, cfg_fp);
`ifdef MATMUL_APB_POLL_TIMEOUT_EN
                    to_flag      <= 1'b0;
                    timeout_err  <= 1'b0;
`endif
                end
                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: if (apb.PREADY) begin
                    if (step == 4'd9) begin
                        state       <= DONE;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        op_done     <= 1'b1;
`ifdef MATMUL_APB_POLL_TIMEOUT_EN
                        timeout_err <= to_flag;
`endif
                    end else if (step == 4'd8) begin
                        if (poll_exit) begin
                            op_exception <= stat_exc;
`ifdef MATMUL_APB_POLL_TIMEOUT_EN
                            to_flag      <= poll_abort && !(stat_done || stat_exc);
`endif
                            issue(4'd9);
                        end else if (POLL_GAP > 0) begin
                            state       <= POLL_WAIT;
                            apb.PSEL    <= 1'b0;
                            apb.PENABLE <= 1'b0;
                        end else begin
                            issue(4'd8);
                        end
                    end else begin
                        issue(4'(step + 4'd1));
                    end
                end
                POLL_WAIT: if (gap_zero) begin
`ifdef MATMUL_APB_POLL_TIMEOUT_EN
                    if (poll_abort) to_flag <= 1'b1;
`endif
                    issue(poll_abort ? 4'd9 : 4'd8);
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/matmul_apb_master.md
Name: matmul_apb_master

Overview:
- APB initiator that programs the matmul accelerator's APB register slave from a single host-side "launch" request.
- Per launch, it:
  - writes the address and stride registers and the FP register;
  - sets START;
  - polls the status register until done or an exception;
  - clears START;
  - reports completion.
- Sits between a host/control FSM and the accelerator's APB slave port.

Parameters:
- ADDR_WIDTH, 16, PADDR width.
- DATA_WIDTH, 5, PWDATA/PRDATA width.
- AWIDTH, 10, width of matrix base-address inputs.
- ADDR_STRIDE_WIDTH, 8, width of stride inputs.
- POLL_GAP, 4, idle cycles between consecutive status reads (0 = back-to-back).
- TIMEOUT_CYCLES, 1024, poll timeout in cycles (used only with the optional feature).

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  launch request.
- cfg_ready  out  1  high when a launch can be accepted.
- cfg_fp  in  1  FP mode bit.
- cfg_addr_a / cfg_addr_b / cfg_addr_c  in  AWIDTH  matrix base addresses.
- cfg_stride_a / cfg_stride_b / cfg_stride_c  in  ADDR_STRIDE_WIDTH  strides.
- busy  out  1  launch in progress.
- op_done  out  1  one-cycle completion pulse.
- op_exception  out  1  exception status captured at completion; held until the next accept.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB write.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Clock and reset: one clock, PCLK. Reset is asynchronous, active-low, on PRESETn.
- Reset values:
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
  - busy=0, op_done=0, op_exception=0;
  - cfg_ready=1;
  - state=IDLE, step=0.
- Reset mid-transfer aborts the transfer immediately. The master does not resume; the host must relaunch.
- Accept: the launch is accepted on a cycle where cfg_valid & cfg_ready.
  - All cfg_* inputs are registered at accept.
  - cfg_ready=0 from the next cycle until op_done; cfg_valid while busy is ignored.
- Step sequence (step index 0..9):
  - 0: write address 4 (ADDR_A) with cfg_addr_a.
  - 1: write address 5 (ADDR_B) with cfg_addr_b.
  - 2: write address 6 (ADDR_C) with cfg_addr_c.
  - 3: write address 7 (STRIDE_A) with cfg_stride_a.
  - 4: write address 8 (STRIDE_B) with cfg_stride_b.
  - 5: write address 9 (STRIDE_C) with cfg_stride_c.
  - 6: write address 3 (FP) with {0…, fp}.
  - 7: write address 1 (START) with 1.
  - 8: read address 2 (status), repeated until exit.
  - 9: write address 1 (START) with 0.
- Write data width: PWDATA carries the low DATA_WIDTH bits of each value, zero-extended if narrower.
- APB phases:
  - SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA valid.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY=1. A transfer completes on the cycle where PSEL & PENABLE & PREADY.
  - Address, control and write data stay stable from SETUP through completion.
- FSM states and transitions:
  - IDLE → SETUP on accept.
  - SETUP → ACCESS, always after one cycle.
  - ACCESS → SETUP on completion when the next step exists and no gap is needed (back-to-back transfers allowed; PSEL stays 1, PENABLE=0).
  - ACCESS → POLL_WAIT after a step-8 read where done and exception are both 0, if POLL_GAP>0. The gap counter counts POLL_GAP cycles, then → SETUP. During POLL_WAIT, PSEL=0 and PENABLE=0.
  - ACCESS → SETUP after a step-8 read where done and exception are both 0, if POLL_GAP=0.
  - ACCESS → DONE after completing step 9.
  - DONE → IDLE after one cycle. op_done=1 in DONE; cfg_ready returns to 1 in IDLE.
- Status decode: sampled from PRDATA at read completion. Bit 1 = done, bit 2 = exception.
  - Either bit = 1 ends polling; go to step 9.
  - op_exception is set to the sampled bit 2.
- Both done and exception in one read: treat as a single completion with op_exception=1.
- busy: 1 from the cycle after accept through DONE inclusive.
- Latency: with PREADY tied high, steps 0–7 take 16 cycles.

Optional Feature:
- Macro: MATMUL_APB_POLL_TIMEOUT_EN.
- When defined:
  - a cycle counter runs during step 8, reset at entry to step 8;
  - on reaching TIMEOUT_CYCLES, polling is abandoned at the next transfer boundary; go to step 9;
  - a new output port timeout_err (1 bit, reset 0) is set at DONE and held until the next accept.
- When undefined:
  - no counter and no port;
  - polling continues indefinitely.

Decomposition:
- Package matmul_apb_pkg contains:
  - register address constants REG_START_ADDR=1, REG_DONE_ADDR=2, REG_FP=3, REG_ADDR_A..REG_STRIDE_C=4..9;
  - status bit indices STAT_START=0, STAT_DONE=1, STAT_EXC=2, STAT_FP=3;
  - the state_t enum: IDLE, SETUP, ACCESS, POLL_WAIT, DONE.
- Sub-module apb_poll_timer: loadable down-counter used for both the POLL_GAP and timeout counts.

Test Plan:
- Launch with addr_a=3, addr_b=7, addr_c=12, strides=1/2/3, fp=1, PREADY=1, done=1 on the first read → writes appear in order 4:3, 5:7, 6:12, 7:1, 8:2, 9:3, 3:1, 1:1; one read of address 2; then write 1:0; single op_done pulse; op_exception=0.
- PREADY low for 3 cycles on each ACCESS → PADDR/PWDATA stable throughout; each transfer takes 5 cycles; sequence unchanged.
- Status returns 0 for 3 reads, then 5'b00010, with POLL_GAP=4 → 4 reads separated by 4 idle cycles (PSEL=0); op_done follows step 9.
- Status returns 5'b00100 → polling ends; START cleared; op_done with op_exception=1.
- PRESETn asserted during step 3 ACCESS → PSEL and PENABLE go 0 asynchronously; cfg_ready=1 after release; a new launch starts at step 0.
- With MATMUL_APB_POLL_TIMEOUT_EN, TIMEOUT_CYCLES=50, status stuck at 0 → START=0 write occurs; timeout_err=1; op_done pulses once.
